demux1t2_32_reg: RTL
====================

// Module: demux1t2_32_reg
// PURPOSE
//  Registered 1-to-2 steering demultiplexer with valid/ready handshakes: the write-side
//  counterpart of the 2:1 operand/result multiplexers in the 5-stage pipeline.
//  - Takes one 32-bit producer stream and delivers each word to exactly one of two consumers.
//  - Used for store-data / writeback routing to two destinations, e.g. data RAM vs MMIO.
//  - Each output has a one-entry holding register, so a stalled consumer never loses data.
//  - Per-output counters record how many words have been accepted for each destination.
// PARAMETERS
//  WIDTH      32   data width of input and both outputs
//  CNT_WIDTH  16   width of the per-output accepted-word counters
// PORTS
//  clk        in   1          rising-edge clock, the only clock
//  rst_n      in   1          reset: asynchronous assertion, active low
//  i_data     in   WIDTH      input word
//  i_sel      in   1          destination of i_data: 0 -> port 0, 1 -> port 1
//  i_valid    in   1          i_data/i_sel valid
//  i_ready    out  1          block can accept the current word (combinational)
//  o0_data    out  WIDTH      port-0 held word
//  o0_valid   out  1          port-0 word valid
//  o0_ready   in   1          port-0 consumer accepts
//  o1_data    out  WIDTH      port-1 held word
//  o1_valid   out  1          port-1 word valid
//  o1_ready   in   1          port-1 consumer accepts
//  cnt0       out  CNT_WIDTH  words accepted for port 0
//  cnt1       out  CNT_WIDTH  words accepted for port 1
// BEHAVIOUR
//  - Reset, asserted asynchronously:
//    - o0_valid = o1_valid = 0; o0_data = o1_data = 0; cnt0 = cnt1 = 0.
//    - Held words are discarded, including when reset is asserted mid-stall.
//    - The first accept is possible at the first rising edge after rst_n rises.
//  - Input handshake:
//    - The input accepts a word when i_valid && i_ready at a rising edge.
//    - Define room_N = !oN_valid || oN_ready.
//    - i_ready = i_sel ? room_1 : room_0. This is combinational from i_sel/oN_valid/oN_ready;
//      there is no path from i_valid to i_ready.
//  - Slot N, evaluated at each edge:
//    - Accept with i_sel==N: oN_data <= i_data, oN_valid <= 1, cntN <= cntN + 1.
//    - Else, if oN_valid && oN_ready: oN_valid <= 0; oN_data holds its last value.
//    - Else: no change.
//  - Latency: a word accepted at edge k appears at port N with oN_valid=1 from edge k to k+1.
//    Throughput is 1 word/cycle per port while oN_ready is held high.
//  - Stability: while oN_valid && !oN_ready, oN_data and oN_valid do not change.
//  - Boundary and simultaneous cases:
//    - Drain and refill of the same slot in the same cycle: valid stays 1, data is the new word,
//      no bubble.
//    - Slot full and its consumer not ready: i_ready = 0 for that i_sel; the word waits upstream.
//    - The other port drains independently in the same cycle; no head-of-line coupling between
//      slots.
//    - i_sel may change while i_valid && !i_ready; i_ready re-evaluates for the new target.
//      No word is ever duplicated to both ports.
//    - Counter at all-ones plus one accept: wraps to 0, no flag.
//  - Ordering: per-port order equals input order; no cross-port ordering guarantee.
// STRUCTURE
//  - Shared package pipe_pkg:
//    - localparams PORT0 = 1'b0, PORT1 = 1'b1.
//    - Default data width DATA_W = 32.
//  - Sub-module out_slot: one-entry valid/data register with counter.
//    - Ports: clk, rst_n, load, data_in, ready, valid, data_out, room, cnt.
//    - Instantiated twice. The top level holds only the i_sel decode and the i_ready mux.
// TESTING
//  1. Reset: hold rst_n=0 with i_valid=1 -> all valids 0, data 0, counters 0, no accept.
//     Release rst_n -> first accept at the next edge.
//  2. Streaming: both oN_ready=1; send 0x11111111 (sel 0), 0x22222222 (sel 1), 0x33333333 (sel 0)
//     on consecutive cycles -> each word appears one cycle later on its port; cnt0=2, cnt1=1;
//     i_ready is always 1.
//  3. Backpressure: o0_ready=0; send 0xAAAA0001 (sel 0) then 0xAAAA0002 (sel 0).
//     -> second word waits with i_ready=0; o0_data holds 0xAAAA0001.
//     Raise o0_ready -> 0xAAAA0002 is loaded in the same edge as the drain; o0_valid never drops.
//  4. Independence: o0 stalled and full; send 0xBEEF0000 with sel 1, o1_ready=1
//     -> accepted immediately; cnt1 increments; port 0 unchanged.
//  5. Wrap and reset mid-stall: preload cnt0 to 0xFFFF via accepts; one more accept -> cnt0=0.
//     Assert rst_n low while o1 is held and stalled -> o1_valid drops immediately,
//     asynchronously, before the next edge.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared constants for the pipeline steering/mux blocks:
//                destination port encodings and the default datapath width.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Destination encodings carried on a steering select line
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Default datapath width of the pipeline
    localparam int DATA_W = 32;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/out_slot.sv
`default_nettype none
// ============================================================================
//  Module      : out_slot
//  Description : One-entry valid/data holding register for a single consumer,
//                with a wrapping count of words loaded into it.
//  Revision    : 1.0 - initial release
// ============================================================================
module out_slot
    import pipe_pkg::*;
#(
    parameter int WIDTH     = DATA_W,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 ready,
    output logic                 valid,
    output logic [WIDTH-1:0]     data_out,
    output logic                 room,
    output logic [CNT_WIDTH-1:0] cnt
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 valid_q, valid_d;
    logic [WIDTH-1:0]     data_q,  data_d;
    logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;

    // The slot can take a word if it is empty or is being drained this cycle.
    // Keeping this free of the load term is what lets a drain and a refill
    // happen on the same edge without a bubble.
    assign room = !valid_q || ready;

    // Next-state: a load wins over a drain, so a same-cycle drain/refill keeps
    // valid high with the new word. On a plain drain the data is left as-is.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = data_in;
            cnt_d   = cnt_q + C_CNT_ONE;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers; reset discards any held word immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid    = valid_q;
    assign data_out = data_q;
    assign cnt      = cnt_q;

endmodule : out_slot
`default_nettype wire

// File: rtl/demux1t2_32_reg.sv
`default_nettype none
// ============================================================================
//  Module      : demux1t2_32_reg
//  Description : Registered 1-to-2 steering demultiplexer with valid/ready
//                handshakes. Each input word goes to exactly one of two
//                consumers, each backed by its own one-entry holding slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux1t2_32_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH     = DATA_W,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     i_data,
    input  logic                 i_sel,
    input  logic                 i_valid,
    output logic                 i_ready,
    output logic [WIDTH-1:0]     o0_data,
    output logic                 o0_valid,
    input  logic                 o0_ready,
    output logic [WIDTH-1:0]     o1_data,
    output logic                 o1_valid,
    input  logic                 o1_ready,
    output logic [CNT_WIDTH-1:0] cnt0,
    output logic [CNT_WIDTH-1:0] cnt1
);

    logic w_room0;
    logic w_room1;
    logic w_accept;
    logic w_load0;
    logic w_load1;

    // Ready follows only the selected slot's room, never i_valid, so a
    // stalled slot cannot block traffic headed for the other one.
    assign i_ready  = (i_sel == PORT1) ? w_room1 : w_room0;
    assign w_accept = i_valid && i_ready;

    // Exactly one slot is loaded per accept, so a word is never duplicated.
    assign w_load0  = w_accept && (i_sel == PORT0);
    assign w_load1  = w_accept && (i_sel == PORT1);

    out_slot #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_slot0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load0),
        .data_in  (i_data),
        .ready    (o0_ready),
        .valid    (o0_valid),
        .data_out (o0_data),
        .room     (w_room0),
        .cnt      (cnt0)
    );

    out_slot #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_slot1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load1),
        .data_in  (i_data),
        .ready    (o1_ready),
        .valid    (o1_valid),
        .data_out (o1_data),
        .room     (w_room1),
        .cnt      (cnt1)
    );

endmodule : demux1t2_32_reg
`default_nettype wire
